// File: rtl/jk_pkg.sv
// Shared JK cell codes and controller states.
// Imported by jk_excite and jk_bank_driver.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/jk_excite.sv
// Per-bit J/K excitation: q (current), t (target), mode (0 set/reset, 1 toggle)
// -> jk = {J,K}; equal bits always hold.
module jk_excite
  import jk_pkg::*;
(
  input  logic       q,
  input  logic       t,
  input  logic       mode,
  output logic [1:0] jk
);

  always_comb begin
    jk = JK_HOLD;
    if (q != t) begin
      if (mode) jk = JK_TGL;
      else if (t) jk = JK_SET;
      else jk = JK_RST;
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flop bank toward a target word with bounded retries.
// Ports: cmd_* handshake in, jk excitation out, q_in readback, done/err/err_mask.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_target,
  input  logic           cmd_mode,
  output logic [2*N-1:0] jk,
  input  logic [N-1:0]   q_in,
  output logic           done,
  output logic           err,
  output logic [N-1:0]   err_mask
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e         state_q, state_d;
  logic [N-1:0]   target_q, target_d;
  logic           mode_q, mode_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           ready_q, ready_d;
  logic [2*N-1:0] jk_q, jk_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [N-1:0]   mask_q, mask_d;

  // jk is registered: excitation is computed on the edge entering DRIVE,
  // from the command being accepted (IDLE) or the held target (retry).
  logic [N-1:0]   src_t;
  logic           src_m;
  logic [2*N-1:0] exc;

  assign src_t = (state_q == IDLE) ? cmd_target : target_q;
  assign src_m = (state_q == IDLE) ? cmd_mode : mode_q;

  for (genvar i = 0; i < N; i++) begin : g_exc
    jk_excite u_exc (
      .q    (q_in[i]),
      .t    (src_t[i]),
      .mode (src_m),
      .jk   (exc[2*i+1:2*i])
    );
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    retry_d  = retry_q;
    err_d    = err_q;
    mask_d   = mask_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          mode_d   = cmd_mode;
          retry_d  = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_in == target_q) begin
          state_d = DONE;
          err_d   = 1'b0;
          mask_d  = '0;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
          mask_d  = q_in ^ target_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
    jk_d    = (state_d == DRIVE) ? exc : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      mode_q   <= 1'b0;
      retry_q  <= '0;
      ready_q  <= 1'b1;
      jk_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      retry_q  <= retry_d;
      ready_q  <= ready_d;
      jk_q     <= jk_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
    end
  end

  assign cmd_ready = ready_q;
  assign jk        = jk_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = mask_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: JK bank model with stuck bits,
// directed plan cases plus randomized commands vs a reference model.
module tb_jk_bank_driver;

  localparam int N  = 4;
  localparam int MR = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [N-1:0]   cmd_target;
  logic           cmd_mode;
  logic [2*N-1:0] jk;
  logic [N-1:0]   q_in;
  logic           done;
  logic           err;
  logic [N-1:0]   err_mask;

  logic [N-1:0]   bank_q;
  logic [N-1:0]   stuck_m;
  logic [N-1:0]   stuck_v;
  logic           load_en;
  logic [N-1:0]   load_v;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.N(N), .MAX_RETRY(MR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_mode   (cmd_mode),
    .jk         (jk),
    .q_in       (q_in),
    .done       (done),
    .err        (err),
    .err_mask   (err_mask)
  );

  assign q_in = bank_q;

  function automatic logic [N-1:0] apply_jk(
    input logic [N-1:0] q, input logic [2*N-1:0] e);
    logic [N-1:0] r;
    r = q;
    for (int i = 0; i < N; i++) begin
      case (e[2*i+:2])
        2'b01: r[i] = 1'b0;
        2'b10: r[i] = 1'b1;
        2'b11: r[i] = ~q[i];
        default: r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (load_en) bank_q <= load_v;
    else bank_q <= (apply_jk(bank_q, jk) & ~stuck_m) | (stuck_v & stuck_m);
  end

  // Reference excitation: differing bits get toggle, or J=t,K=~t.
  function automatic logic [2*N-1:0] exp_jk(
    input logic [N-1:0] q, input logic [N-1:0] t, input logic m);
    logic [2*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (q[i] != t[i]) r[2*i+:2] = m ? 2'b11 : {t[i], ~t[i]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [N-1:0] v);
    @(negedge clk);
    load_en = 1'b1;
    load_v  = (v & ~stuck_m) | (stuck_v & stuck_m);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One full command; busy cycles get random ignored cmd_valid traffic.
  task automatic run_cmd(input string nm, input logic [N-1:0] t,
                         input logic m);
    logic [N-1:0] fin;
    int att;
    int d;
    fin = (t & ~stuck_m) | (stuck_v & stuck_m);
    att = (fin == t) ? 1 : MR + 1;
    d   = 1 + 2 * att;
    @(negedge clk);
    check({nm, "_rdy0"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_mode   = m;
    for (int idx = 1; idx <= d + 1; idx++) begin
      @(negedge clk);
      check($sformatf("%s_jk%0d", nm, idx), 32'(jk),
            32'(((idx % 2) == 1 && idx < d) ?
                exp_jk(bank_q, t, m) : '0));
      check($sformatf("%s_done%0d", nm, idx), 32'(done), 32'(idx == d));
      check($sformatf("%s_rdy%0d", nm, idx), 32'(cmd_ready),
            32'(idx == d + 1));
      if (idx >= d) begin
        check($sformatf("%s_err%0d", nm, idx), 32'(err), 32'(fin != t));
        check($sformatf("%s_msk%0d", nm, idx), 32'(err_mask),
              32'(fin ^ t));
      end
      if (idx <= d) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_target = N'($urandom);
        cmd_mode   = 1'($urandom_range(0, 1));
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b1;
    cmd_target = '1;
    cmd_mode   = 1'b0;
    stuck_m    = '0;
    stuck_v    = '0;
    load_en    = 1'b1;
    load_v     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(cmd_ready), 32'd1);
    check("rst_jk", 32'(jk), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_msk", 32'(err_mask), 32'd0);
    cmd_valid = 1'b0;
    load_en   = 1'b0;
    rst_n     = 1'b1;

    preload(4'b0000);
    run_cmd("sr", 4'b1010, 1'b0);
    check("sr_bank", 32'(bank_q), 32'h a);

    preload(4'b1111);
    run_cmd("tgl", 4'b0110, 1'b1);
    check("tgl_bank", 32'(bank_q), 32'h6);

    stuck_m = 4'b0001;
    stuck_v = 4'b0000;
    preload(4'b0000);
    run_cmd("stuck", 4'b0001, 1'b0);
    stuck_m = '0;

    preload(4'b0101);
    run_cmd("noop", 4'b0101, 1'b0);

    preload(4'b0000);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = 4'b1111;
    cmd_mode   = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abt_jk", 32'(jk), 32'd0);
    check("abt_rdy", 32'(cmd_ready), 32'd1);
    check("abt_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abt_nodone%0d", i), 32'(done), 32'd0);
    end
    run_cmd("post", 4'b0011, 1'b1);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        stuck_m = N'($urandom);
        stuck_v = N'($urandom);
      end else begin
        stuck_m = '0;
      end
      preload(N'($urandom));
      run_cmd($sformatf("r%0d", n), N'($urandom),
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
